// File: rtl/fg_waveform_analyzer_pkg.sv
// ---------------------------------------------------------------------------
// fg_waveform_analyzer_pkg
//   Definitions shared by the function generator and its waveform analyzer:
//   the waveform FSM state encoding and the default datapath widths.
//   Contents:
//     FG_COUNTER_BW   default width of period / ON sample counters
//     FG_WAVEFORM_BW  default amplitude width (sample is one bit wider, signed)
//     fg_state_e      IDLE=0, RISE=1, ON=2, FALL=3
// ---------------------------------------------------------------------------
package fg_waveform_analyzer_pkg;

    localparam int FG_COUNTER_BW  = 32;
    localparam int FG_WAVEFORM_BW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_ON   = 2'd2,
        ST_FALL = 2'd3
    } fg_state_e;

endpackage

// File: rtl/fg_step_classifier.sv
// ---------------------------------------------------------------------------
// fg_step_classifier
//   Clamps the incoming signed sample at zero, keeps the previous clamped
//   sample and classifies the step d = x - prev.
//   Ports:
//     clk_i, rstn_i   clock, asynchronous active-low reset
//     i_en            sample strobe; prev only advances when high
//     i_sample        signed sample, WAVEFORM_BITWIDTH+1 bits
//     o_x             clamped sample (non-negative, WAVEFORM_BITWIDTH bits)
//     o_d             step x - prev, WAVEFORM_BITWIDTH+2 bits signed
//     o_d_pos/zero/neg, o_x_zero   classification flags
// ---------------------------------------------------------------------------
module fg_step_classifier #(
    parameter int WAVEFORM_BITWIDTH = 16
) (
    input  logic                                clk_i,
    input  logic                                rstn_i,
    input  logic                                i_en,
    input  logic [WAVEFORM_BITWIDTH:0]          i_sample,
    output logic [WAVEFORM_BITWIDTH-1:0]        o_x,
    output logic signed [WAVEFORM_BITWIDTH+1:0] o_d,
    output logic                                o_d_pos,
    output logic                                o_d_zero,
    output logic                                o_d_neg,
    output logic                                o_x_zero
);
    localparam int WB = WAVEFORM_BITWIDTH;

    logic [WB-1:0] r_prev;

    // Negative samples clamp to zero; the remaining value always fits in WB bits.
    assign o_x = i_sample[WB] ? '0 : i_sample[WB-1:0];

    // Two guard bits keep the difference of two WB-bit unsigned values exact.
    assign o_d      = $signed({2'b00, o_x}) - $signed({2'b00, r_prev});
    assign o_d_neg  = o_d[WB+1];
    assign o_d_zero = (o_d == '0);
    assign o_d_pos  = !o_d_neg && !o_d_zero;
    assign o_x_zero = (o_x == '0);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            r_prev <= '0;
        else if (i_en)
            r_prev <= o_x;
    end

endmodule

// File: rtl/fg_waveform_analyzer.sv
// ---------------------------------------------------------------------------
// fg_waveform_analyzer
//   Recovers period, ON time, peak amplitude and first rise/fall steps of the
//   trapezoid/pulse waveform coming out of the generator's waveform stage.
//   A measurement is published (meas_valid_o pulse) at every rise start that
//   has a previous rise start since reset/clear.
//   Ports:
//     clk_i, rstn_i   clock, asynchronous active-low reset
//     clk_en_i        sample strobe, all state holds while low
//     clear_i         sync clear of FSM/counter/history, outputs keep values
//     sample_i        signed sample, WAVEFORM_BITWIDTH+1 bits
//     meas_valid_o    one-cycle publish pulse
//     period_o        samples between successive rise starts (saturating)
//     on_count_o      samples from rise start to fall start (0 if no fall)
//     amplitude_o     peak sample of the cycle
//     k_rise_o        first rise step (x - prev at rise start)
//     k_fall_o        first fall step (prev - x at fall start)
//     meas_ovf_o      the published cycle saturated the counter
//   Build option: FG_SLOPE_MEAS_EN enables the rise/fall step shadows;
//   without it k_rise_o / k_fall_o are tied to 0.
// ---------------------------------------------------------------------------
module fg_waveform_analyzer
    import fg_waveform_analyzer_pkg::*;
#(
    parameter int COUNTER_BITWIDTH  = FG_COUNTER_BW,
    parameter int WAVEFORM_BITWIDTH = FG_WAVEFORM_BW
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         clk_en_i,
    input  logic                         clear_i,
    input  logic [WAVEFORM_BITWIDTH:0]   sample_i,
    output logic                         meas_valid_o,
    output logic [COUNTER_BITWIDTH-1:0]  period_o,
    output logic [COUNTER_BITWIDTH-1:0]  on_count_o,
    output logic [WAVEFORM_BITWIDTH-1:0] amplitude_o,
    output logic [WAVEFORM_BITWIDTH-1:0] k_rise_o,
    output logic [WAVEFORM_BITWIDTH-1:0] k_fall_o,
    output logic                         meas_ovf_o
);
    localparam int CB = COUNTER_BITWIDTH;
    localparam int WB = WAVEFORM_BITWIDTH;
    localparam logic [CB-1:0] CNT_MAX = '1;

    logic [WB-1:0]        w_x;
    logic signed [WB+1:0] w_d;
    logic                 w_d_pos, w_d_zero, w_d_neg, w_x_zero;

    fg_step_classifier #(
        .WAVEFORM_BITWIDTH (WB)
    ) u_step (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .i_en     (clk_en_i),
        .i_sample (sample_i),
        .o_x      (w_x),
        .o_d      (w_d),
        .o_d_pos  (w_d_pos),
        .o_d_zero (w_d_zero),
        .o_d_neg  (w_d_neg),
        .o_x_zero (w_x_zero)
    );

    fg_state_e     r_state, w_state_nxt;
    logic          w_rise_start, w_fall_start;
    logic [CB-1:0] r_cnt, w_cnt_inc;
    logic          r_have_start;
    logic [CB-1:0] r_on_s;
    logic [WB-1:0] r_peak_s;
    logic          r_ovf_s;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            r_state <= ST_IDLE;
        else if (clear_i)
            r_state <= ST_IDLE;
        else if (clk_en_i)
            r_state <= w_state_nxt;
    end

    // Only entries into RISE from IDLE/FALL start a new cycle; ON->RISE is a
    // second ramp within the same cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_rise_start = 1'b0;
        w_fall_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_d_pos) begin
                    w_state_nxt  = ST_RISE;
                    w_rise_start = 1'b1;
                end
            end
            ST_RISE: begin
                if (w_d_zero) begin
                    w_state_nxt = ST_ON;
                end else if (w_d_neg) begin
                    w_state_nxt  = ST_FALL;
                    w_fall_start = 1'b1;
                end
            end
            ST_ON: begin
                if (w_d_neg) begin
                    w_state_nxt  = ST_FALL;
                    w_fall_start = 1'b1;
                end else if (w_d_pos) begin
                    w_state_nxt = ST_RISE;
                end
            end
            ST_FALL: begin
                if (w_d_pos) begin
                    w_state_nxt  = ST_RISE;
                    w_rise_start = 1'b1;
                end else if (w_x_zero) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CB'(1);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt        <= '0;
            r_have_start <= 1'b0;
            r_on_s       <= '0;
            r_peak_s     <= '0;
            r_ovf_s      <= 1'b0;
            meas_valid_o <= 1'b0;
            period_o     <= '0;
            on_count_o   <= '0;
            amplitude_o  <= '0;
            meas_ovf_o   <= 1'b0;
        end else if (clear_i) begin
            r_cnt        <= '0;
            r_have_start <= 1'b0;
            r_on_s       <= '0;
            r_peak_s     <= '0;
            r_ovf_s      <= 1'b0;
            meas_valid_o <= 1'b0;
        end else if (clk_en_i) begin
            meas_valid_o <= 1'b0;
            if (w_rise_start) begin
                // Publish the finished cycle from the shadows, then reload them.
                if (r_have_start) begin
                    meas_valid_o <= 1'b1;
                    period_o     <= r_cnt;
                    on_count_o   <= r_on_s;
                    amplitude_o  <= r_peak_s;
                    meas_ovf_o   <= r_ovf_s;
                end
                r_have_start <= 1'b1;
                r_cnt        <= CB'(1);
                r_on_s       <= '0;
                r_peak_s     <= w_x;
                r_ovf_s      <= 1'b0;
            end else begin
                r_cnt <= w_cnt_inc;
                if (w_cnt_inc == CNT_MAX)
                    r_ovf_s <= 1'b1;
                if (w_x > r_peak_s)
                    r_peak_s <= w_x;
                if (w_fall_start)
                    r_on_s <= r_cnt;
            end
        end else begin
            meas_valid_o <= 1'b0;
        end
    end

`ifdef FG_SLOPE_MEAS_EN
    logic signed [WB+1:0] w_neg_d;
    logic [WB-1:0]        r_k_rise_s, r_k_fall_s;
    logic                 w_unused_slope;

    assign w_neg_d        = -w_d;
    assign w_unused_slope = ^{w_d[WB+1:WB], w_neg_d[WB+1:WB]};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_k_rise_s <= '0;
            r_k_fall_s <= '0;
            k_rise_o   <= '0;
            k_fall_o   <= '0;
        end else if (clear_i) begin
            r_k_rise_s <= '0;
            r_k_fall_s <= '0;
        end else if (clk_en_i) begin
            if (w_rise_start) begin
                if (r_have_start) begin
                    k_rise_o <= r_k_rise_s;
                    k_fall_o <= r_k_fall_s;
                end
                r_k_rise_s <= w_d[WB-1:0];
                r_k_fall_s <= '0;
            end else if (w_fall_start) begin
                r_k_fall_s <= w_neg_d[WB-1:0];
            end
        end
    end
`else
    logic w_unused_d;
    assign w_unused_d = ^w_d;
    assign k_rise_o   = '0;
    assign k_fall_o   = '0;
`endif

endmodule
